// File: rtl/mma_pkg.sv
// Shared types and width helpers for the MMA tile accumulator.
// Contents:
//   mma_state_e    - controller state encoding (IDLE, ACCUM, OUT)
//   acc_width      - accumulator/result element width for a given operand width
//   tile_cnt_width - width of a counter that has to hold 0..max_tiles
package mma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } mma_state_e;

  // A product of two P-bit operands needs 2P bits. Accumulating in 4P leaves
  // plenty of headroom before the result wraps.
  function automatic int acc_width(input int p);
    return 4 * p;
  endfunction

  function automatic int tile_cnt_width(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

endpackage

// File: rtl/mma_tile_dot.sv
// Combinational M x N array of K-element signed dot products for one tile.
// Ports:
//   a   - A tile, [M][K] signed P-bit elements
//   b   - B tile, [K][N] signed P-bit elements
//   dot - [M][N] dot products, each product sign-extended to ACC_W before summing
module mma_tile_dot
  import mma_pkg::*;
#(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int K     = 2,
  parameter int P     = 8,
  parameter int ACC_W = acc_width(P)
) (
  input  logic [M-1:0][K-1:0][P-1:0]     a,
  input  logic [K-1:0][N-1:0][P-1:0]     b,
  output logic [M-1:0][N-1:0][ACC_W-1:0] dot
);

  function automatic logic [ACC_W-1:0] mul_ext(input logic [P-1:0] x, input logic [P-1:0] y);
    logic signed [2*P-1:0] prod;
    prod = $signed(x) * $signed(y);
    return {{(ACC_W-2*P){prod[2*P-1]}}, prod};
  endfunction

  always_comb begin
    dot = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < K; k++) begin
          dot[i][j] = dot[i][j] + mul_ext(a[i][k], b[k][j]);
        end
      end
    end
  end

endmodule

// File: rtl/mma_tile_accumulator.sv
// Streams K-tiles of A and B and accumulates D = C0 + sum_t A_t x B_t on a
// fixed M x N x K datapath. One job covers a runtime number of tiles.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start_i, num_tiles_i      - job start (IDLE only) and tile count (clamped to MAX_TILES)
//   init_mode_i, C_i          - accumulator starts at C_i when init_mode_i=1, else zero
//   in_valid_i, in_ready_o    - tile handshake for A_i / B_i
//   out_valid_o, out_ready_i  - result handshake for D_o
//   busy_o                    - high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for start_i; job parameters latched on start
// ACCUM | accepting tiles; stage 1 registers dot products, stage 2 adds them
// OUT   | D_o valid and held until out_ready_i
module mma_tile_accumulator
  import mma_pkg::*;
#(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int P         = 8,
  parameter int MAX_TILES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_i,
  input  logic [$clog2(MAX_TILES+1)-1:0]     num_tiles_i,
  input  logic                               init_mode_i,
  input  logic signed [M-1:0][N-1:0][4*P-1:0] C_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic signed [M-1:0][K-1:0][P-1:0]  A_i,
  input  logic signed [K-1:0][N-1:0][P-1:0]  B_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic signed [M-1:0][N-1:0][4*P-1:0] D_o,
  output logic                               busy_o
);

  localparam int ACC_W = acc_width(P);
  localparam int CNT_W = tile_cnt_width(MAX_TILES);

  mma_state_e state, state_nxt;

  logic [CNT_W-1:0]               num_tiles_q, tile_cnt, num_tiles_clamped;
  logic [M-1:0][N-1:0][ACC_W-1:0] acc, acc_sum, dot, s1_dot, init_val;
  logic                           s1_valid, accept, last_done, start_ok;

  mma_tile_dot #(.M(M), .N(N), .K(K), .P(P), .ACC_W(ACC_W)) u_dot (
    .a   (A_i),
    .b   (B_i),
    .dot (dot)
  );

  assign num_tiles_clamped = (num_tiles_i > CNT_W'(MAX_TILES)) ? CNT_W'(MAX_TILES) : num_tiles_i;
  assign init_val          = init_mode_i ? C_i : '0;
  assign start_ok          = (state == IDLE) && start_i;
  assign accept            = in_valid_i && in_ready_o;
  // tile_cnt already counts the tile sitting in stage 1, so equality means
  // this stage-2 update is the final one of the job.
  assign last_done         = s1_valid && (tile_cnt == num_tiles_q);

  always_comb begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_sum[i][j] = acc[i][j] + s1_dot[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = (num_tiles_clamped == '0) ? OUT : ACCUM;
      end
      ACCUM: begin
        in_ready_o = (tile_cnt < num_tiles_q);
        if (last_done) state_nxt = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_tiles_q <= '0;
      tile_cnt    <= '0;
      acc         <= '0;
      s1_dot      <= '0;
      s1_valid    <= 1'b0;
      D_o         <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_dot   <= dot;
        tile_cnt <= tile_cnt + 1'b1;
      end
      if (start_ok) begin
        num_tiles_q <= num_tiles_clamped;
        tile_cnt    <= '0;
        acc         <= init_val;
        if (num_tiles_clamped == '0) D_o <= init_val;
      end else if (s1_valid) begin
        acc <= acc_sum;
        if (last_done) D_o <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_mma_tile_accumulator.sv
// Directed bench for mma_tile_accumulator (M=N=K=2, P=8, MAX_TILES=16).
module tb_mma_tile_accumulator;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start_i;
  logic [4:0]                    num_tiles_i;
  logic                          init_mode_i;
  logic signed [1:0][1:0][31:0]  C_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic signed [1:0][1:0][7:0]   A_i;
  logic signed [1:0][1:0][7:0]   B_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic signed [1:0][1:0][31:0]  D_o;
  logic                          busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int accepts;

  mma_tile_accumulator #(.M(2), .N(2), .K(2), .P(8), .MAX_TILES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .num_tiles_i (num_tiles_i),
    .init_mode_i (init_mode_i),
    .C_i         (C_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .A_i         (A_i),
    .B_i         (B_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .D_o         (D_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_d(input string tag, input int e00, input int e01, input int e10, input int e11);
    chk({tag, "_d00"}, D_o[0][0], e00);
    chk({tag, "_d01"}, D_o[0][1], e01);
    chk({tag, "_d10"}, D_o[1][0], e10);
    chk({tag, "_d11"}, D_o[1][1], e11);
  endtask

  task automatic set_tile(input int a00, input int a01, input int a10, input int a11,
                          input int b00, input int b01, input int b10, input int b11);
    A_i[0][0] = a00[7:0]; A_i[0][1] = a01[7:0]; A_i[1][0] = a10[7:0]; A_i[1][1] = a11[7:0];
    B_i[0][0] = b00[7:0]; B_i[0][1] = b01[7:0]; B_i[1][0] = b10[7:0]; B_i[1][1] = b11[7:0];
  endtask

  // Presents one tile for one cycle, then drives junk so that stale
  // operands would show up in the result if wrongly captured.
  task automatic send_tile(input int a00, input int a01, input int a10, input int a11,
                           input int b00, input int b01, input int b10, input int b11);
    set_tile(a00, a01, a10, a11, b00, b01, b10, b11);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    set_tile(99, 99, 99, 99, 99, 99, 99, 99);
  endtask

  task automatic start_job(input int n, input logic init, input int c);
    num_tiles_i = 5'(n);
    init_mode_i = init;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        C_i[i][j] = c;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk({tag, "_done_valid"}, out_valid_o, 1'b0);
    chk({tag, "_done_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; num_tiles_i = '0; init_mode_i = 1'b0; C_i = '0;
    in_valid_i = 1'b0; A_i = '0; B_i = '0; out_ready_i = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk_d("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // 1 tile, zero init, latency accept+2
    start_job(1, 1'b0, 0);
    chk("t1_busy", busy_o, 1'b1);
    chk("t1_ready", in_ready_o, 1'b1);
    send_tile(1, 2, 3, 4, 5, 6, 7, 8);
    chk("t1_valid_t1", out_valid_o, 1'b0);
    chk("t1_ready_after", in_ready_o, 1'b0);
    tick();
    chk("t1_valid_t2", out_valid_o, 1'b1);
    chk_d("t1", 19, 22, 43, 50);
    finish_job("t1");

    // C=100, two back-to-back tiles, input held valid past the job
    start_job(2, 1'b1, 100);
    set_tile(1, 2, 3, 4, 5, 6, 7, 8);
    in_valid_i = 1'b1;
    accepts = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (in_ready_o) accepts++;
      tick();
    end
    in_valid_i = 1'b0;
    chk("t2_accepts", accepts, 2);
    chk("t2_valid", out_valid_o, 1'b1);
    chk_d("t2", 138, 144, 186, 200);
    finish_job("t2");

    // Signed extremes
    start_job(1, 1'b0, 0);
    send_tile(-128, 0, 0, -128, -128, 0, 0, 127);
    tick();
    chk("t3_valid", out_valid_o, 1'b1);
    chk_d("t3", 16384, 0, 0, -16256);
    finish_job("t3");

    // Gaps between tiles, then output stall with a stray start
    start_job(3, 1'b0, 0);
    send_tile(1, 2, 3, 4, 5, 6, 7, 8);
    tick(); chk("t4_gap1_ready", in_ready_o, 1'b1); tick();
    send_tile(1, 0, 0, 1, 2, 3, 4, 5);
    tick(); chk("t4_gap2_ready", in_ready_o, 1'b1); tick();
    send_tile(-1, 0, 0, -1, 1, 1, 1, 1);
    chk("t4_last_ready", in_ready_o, 1'b0);
    tick();
    chk("t4_valid", out_valid_o, 1'b1);
    chk_d("t4", 20, 24, 46, 54);
    for (int cyc = 0; cyc < 5; cyc++) begin
      start_i = (cyc == 2);
      num_tiles_i = 5'd1;
      init_mode_i = 1'b0;
      tick();
      chk("t4_stall_valid", out_valid_o, 1'b1);
      chk("t4_stall_busy", busy_o, 1'b1);
      chk("t4_stall_d00", D_o[0][0], 20);
      chk("t4_stall_d11", D_o[1][1], 54);
    end
    start_i = 1'b0;
    finish_job("t4");
    chk("t4_no_restart_ready", in_ready_o, 1'b0);

    // Reset mid-job after 1 of 3 tiles
    start_job(3, 1'b0, 0);
    send_tile(1, 2, 3, 4, 5, 6, 7, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ready", in_ready_o, 1'b0);
    chk("t5_rst_valid", out_valid_o, 1'b0);
    chk("t5_rst_busy", busy_o, 1'b0);
    chk_d("t5_rst", 0, 0, 0, 0);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t5_idle_ready", in_ready_o, 1'b0);
    chk("t5_idle_busy", busy_o, 1'b0);
    start_job(1, 1'b0, 0);
    send_tile(1, 2, 3, 4, 5, 6, 7, 8);
    tick();
    chk("t5_valid", out_valid_o, 1'b1);
    chk_d("t5", 19, 22, 43, 50);
    finish_job("t5");

    // Zero tiles, C=-5
    start_job(0, 1'b1, -5);
    chk("t6_valid", out_valid_o, 1'b1);
    chk("t6_ready", in_ready_o, 1'b0);
    chk_d("t6", -5, -5, -5, -5);
    finish_job("t6");

    // num_tiles above MAX_TILES clamps to 16
    start_job(20, 1'b0, 0);
    set_tile(1, 0, 0, 1, 1, 0, 0, 1);
    in_valid_i = 1'b1;
    accepts = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (in_ready_o) accepts++;
      tick();
    end
    in_valid_i = 1'b0;
    chk("t7_accepts", accepts, 16);
    chk("t7_valid", out_valid_o, 1'b1);
    chk_d("t7", 16, 0, 0, 16);
    finish_job("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mma_tile_accumulator.md
Name: mma_tile_accumulator

Overview:
- Sequential successor to the combinational MxNxK multiply-accumulate array.
- Accumulates D = C0 + sum over t of A_t x B_t across a runtime-programmed number of streamed K-tiles.
- Each tile arrives over a valid/ready input channel. The result leaves over a valid/ready output channel.
- Sits between the operand-fetch streamers and the result writeback. Allows a GEMM with K_total = num_tiles*K on a fixed MxNxK datapath.

Parameters:
- M, 2, rows of A/C/D
- N, 2, columns of B/C/D
- K, 2, inner dimension per tile
- P, 8, operand width (signed)
- MAX_TILES, 16, maximum tiles per job; counter width = $clog2(MAX_TILES+1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start_i  in  1  job start pulse, honoured only in IDLE
- num_tiles_i  in  $clog2(MAX_TILES+1)  tiles in the job, sampled on start
- init_mode_i  in  1  0: accumulator starts at zero; 1: accumulator starts from C_i (sampled on start)
- C_i  in  [M][N] x 4P signed  initial accumulator value
- in_valid_i  in  1  A_i/B_i tile valid
- in_ready_o  out  1  tile accepted when in_valid_i & in_ready_o
- A_i  in  [M][K] x P signed  A tile
- B_i  in  [K][N] x P signed  B tile
- out_valid_o  out  1  D_o holds the final result
- out_ready_i  in  1  consumer accepts D_o
- D_o  out  [M][N] x 4P signed  result
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE; accumulator, D_o, tile counter and pipeline valid cleared to 0; in_ready_o=0, out_valid_o=0, busy_o=0. Reset has priority over all events, including mid-job: the partial sum is discarded, and any tile in the pipeline is dropped.
- Arithmetic:
  - Each product is a full 2P-bit signed product, sign-extended to 4P.
  - Products are summed in order element 0..K-1 onto the accumulator, modulo 2^(4P) (two's-complement wrap, no saturation, no flag).
- States:
  - IDLE: in_ready_o=0. On start_i, latch num_tiles_i, load the accumulator with C_i (init_mode_i=1) or 0, and clear the tile counter. Go to ACCUM if num_tiles_i>0; otherwise go to OUT next cycle with D_o = initial value.
  - ACCUM: in_ready_o=1 until num_tiles tiles have been accepted, then 0.
    - Stage 1 (accept cycle): the per-cell dot products of the tile are registered with a stage-valid bit.
    - Stage 2 (next cycle): the accumulator is updated with them.
    - Back-to-back tiles are accepted at one per cycle. in_valid_i gaps simply stall.
    - After the last tile's stage-2 update, D_o is loaded from the accumulator and the state goes to OUT.
  - OUT: out_valid_o=1; D_o and out_valid_o held stable until out_ready_i. On the handshake cycle, go to IDLE with out_valid_o=0 the next cycle.
- Latency: the last tile is accepted in cycle t, and out_valid_o is asserted in cycle t+2. For num_tiles=0, start in cycle t gives out_valid_o in cycle t+1.
- start_i outside IDLE is ignored, with no effect on the job in progress.
- in_valid_i outside ACCUM, or after the last tile, is not accepted.
- A/B values are don't-care when in_valid_i is low.
- num_tiles_i > MAX_TILES is clamped to MAX_TILES.
- Throughput: one job per (num_tiles + 3) cycles minimum, with out_ready_i held high.

Decomposition:
- Package mma_pkg:
  - state enum (IDLE, ACCUM, OUT)
  - localparam ACC_W = 4*P derivation helper
  - tile-count width function
- Sub-module mma_tile_dot: combinational. Takes A[M][K] and B[K][N] and produces M x N sign-extended 4P-bit dot products. The top instantiates it once, ahead of the stage-1 register.

Test Plan:
- All scenarios use M=N=K=2, P=8.
- Zero-init, 1 tile, A=[[1,2],[3,4]], B=[[5,6],[7,8]], accepted at cycle t -> out_valid_o at t+2, D=[[19,22],[43,50]].
- init_mode=1, C all 100, num_tiles=2 with the same tile back-to-back -> in_ready_o high for exactly 2 accepts, D=[[138,144],[186,200]].
- Signed extremes, A=[[-128,0],[0,-128]], B=[[-128,0],[0,127]], zero-init -> D=[[16384,0],[0,-16256]].
- Backpressure, num_tiles=3, with 2-cycle in_valid_i gaps between tiles, then out_ready_i low for 5 cycles -> D unchanged and out_valid_o held through the stall; start_i pulsed during OUT is ignored; busy_o=1 until the handshake.
- Reset mid-job after 1 of 3 tiles -> the next cycle shows all outputs 0 and state IDLE; a following 1-tile job with the test-1 operands yields [[19,22],[43,50]], with no residue.
- num_tiles=0, init_mode=1, C all -5 -> in_ready_o never high, out_valid_o one cycle after start, D all -5.
